// File: rtl/fir_channel_arbiter.sv
// fir_channel_arbiter: time-shares one FIR core among NUM_CH sample streams.
// A channel owns the core for a whole packet (up to its last-tagged sample).
// The delay line is cleared whenever ownership changes, each result comes back
// tagged with the channel that produced it, and a watchdog abandons a
// transaction when the core never answers.
module fir_channel_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int CH_W       = 2,
   parameter int IN_WIDTH   = 16,
   parameter int OUT_WIDTH  = 38,
   parameter int CLR_CYCLES = 2,
   parameter int TIMEOUT    = 1023
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH*IN_WIDTH-1:0] ch_data,
   input  logic [NUM_CH-1:0]          ch_valid,
   input  logic [NUM_CH-1:0]          ch_last,
   output logic [NUM_CH-1:0]          ch_ready,
   output logic [IN_WIDTH-1:0]        fir_input,
   output logic                       fir_input_valid,
   output logic                       fir_clr,
   input  logic [OUT_WIDTH-1:0]       fir_output,
   input  logic                       fir_output_valid,
   output logic [OUT_WIDTH-1:0]       out_data,
   output logic [CH_W-1:0]            out_ch,
   output logic                       out_last,
   output logic                       out_valid,
   output logic                       timeout_err,
   output logic                       busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SEND,
      ST_WAIT
   } state_t;

   state_t              state;
   logic [CH_W-1:0]     grant;
   logic [CH_W-1:0]     owner;
   logic                owner_valid;
   logic [CH_W-1:0]     rr_ptr;
   logic [3:0]          clr_cnt;
   logic [15:0]         to_cnt;
   logic                last_q;

   logic [2*NUM_CH-1:0] req_dbl;
   logic [NUM_CH-1:0]   req_rot;
   logic [CH_W:0]       arb_sum;
   logic                arb_found;
   logic [CH_W-1:0]     arb_grant;

   logic [IN_WIDTH-1:0] sel_data;
   logic                sel_valid;
   logic                sel_last;

   // Next channel in round-robin order, wrapping at NUM_CH rather than 2^CH_W.
   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
      if (c == CH_W'(NUM_CH - 1)) begin
         return '0;
      end
      return c + 1'b1;
   endfunction

   // Round-robin search: rotate the request vector so rr_ptr sits at bit 0,
   // take the lowest set bit, then map the offset back to a channel index.
   always_comb begin
      req_dbl   = {ch_valid, ch_valid};
      req_rot   = NUM_CH'(req_dbl >> rr_ptr);
      arb_sum   = '0;
      arb_found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!arb_found && req_rot[i]) begin
            arb_found = 1'b1;
            arb_sum   = {1'b0, rr_ptr} + (CH_W+1)'(i);
         end
      end
      if (arb_sum >= (CH_W+1)'(NUM_CH)) begin
         arb_sum = arb_sum - (CH_W+1)'(NUM_CH);
      end
      arb_grant = arb_sum[CH_W-1:0];
   end

   // Pick out the granted channel's sample/valid/last and drive its accept
   // strobe; only the owner can ever be ready, and only while in SEND.
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      ch_ready  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant == CH_W'(i)) begin
            sel_data    = ch_data[i*IN_WIDTH +: IN_WIDTH];
            sel_valid   = ch_valid[i];
            sel_last    = ch_last[i];
            ch_ready[i] = (state == ST_SEND) && ch_valid[i];
         end
      end
   end

   assign busy = (state != ST_IDLE);

   // Main controller: arbitration in IDLE, delay-line clear on owner change,
   // one sample in flight at a time, and a saturating response watchdog.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= ST_IDLE;
         grant           <= '0;
         owner           <= '0;
         owner_valid     <= 1'b0;
         rr_ptr          <= '0;
         clr_cnt         <= '0;
         to_cnt          <= '0;
         last_q          <= 1'b0;
         fir_input       <= '0;
         fir_input_valid <= 1'b0;
         fir_clr         <= 1'b0;
         out_data        <= '0;
         out_ch          <= '0;
         out_last        <= 1'b0;
         out_valid       <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         fir_input_valid <= 1'b0;
         out_valid       <= 1'b0;
         timeout_err     <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (arb_found) begin
                  grant <= arb_grant;
                  if (!owner_valid || (arb_grant != owner)) begin
                     state   <= ST_CLEAR;
                     fir_clr <= 1'b1;
                     clr_cnt <= '0;
                  end else begin
                     state <= ST_SEND;
                  end
               end
            end

            ST_CLEAR: begin
               if (clr_cnt == 4'(CLR_CYCLES - 1)) begin
                  fir_clr     <= 1'b0;
                  owner       <= grant;
                  owner_valid <= 1'b1;
                  state       <= ST_SEND;
               end else if (clr_cnt != 4'hF) begin
                  clr_cnt <= clr_cnt + 4'd1;
               end
            end

            ST_SEND: begin
               if (sel_valid) begin
                  fir_input       <= sel_data;
                  fir_input_valid <= 1'b1;
                  last_q          <= sel_last;
                  to_cnt          <= '0;
                  state           <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (fir_output_valid) begin
                  out_data  <= fir_output;
                  out_ch    <= grant;
                  out_last  <= last_q;
                  out_valid <= 1'b1;
                  if (last_q) begin
                     rr_ptr <= next_ch(grant);
                     state  <= ST_IDLE;
                  end else begin
                     state <= ST_SEND;
                  end
               end else if (to_cnt == 16'(TIMEOUT)) begin
                  timeout_err <= 1'b1;
                  owner_valid <= 1'b0;
                  rr_ptr      <= next_ch(grant);
                  state       <= ST_IDLE;
               end else if (to_cnt != 16'hFFFF) begin
                  to_cnt <= to_cnt + 16'd1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_channel_arbiter.sv
// tb_fir_channel_arbiter: scenario tasks for fir_channel_arbiter with a
// behavioural FIR core (result = sample * 20 after a fixed delay) and a
// scoreboard queue of expected tagged results.
module tb_fir_channel_arbiter;

   localparam int NUM_CH     = 4;
   localparam int CH_W       = 2;
   localparam int IN_WIDTH   = 16;
   localparam int OUT_WIDTH  = 38;
   localparam int CLR_CYCLES = 2;
   localparam int TIMEOUT    = 1023;

   typedef struct packed {
      logic [OUT_WIDTH-1:0] data;
      logic [CH_W-1:0]      ch;
      logic                 last;
   } exp_t;

   logic                       clk = 1'b0;
   logic                       rst = 1'b0;
   logic [NUM_CH*IN_WIDTH-1:0] ch_data = '0;
   logic [NUM_CH-1:0]          ch_valid = '0;
   logic [NUM_CH-1:0]          ch_last = '0;
   logic [NUM_CH-1:0]          ch_ready;
   logic [IN_WIDTH-1:0]        fir_input;
   logic                       fir_input_valid;
   logic                       fir_clr;
   logic [OUT_WIDTH-1:0]       fir_output;
   logic                       fir_output_valid;
   logic [OUT_WIDTH-1:0]       out_data;
   logic [CH_W-1:0]            out_ch;
   logic                       out_last;
   logic                       out_valid;
   logic                       timeout_err;
   logic                       busy;

   logic                       model_on = 1'b1;
   int                         model_delay = 20;
   int                         model_cnt = 0;
   logic                       model_valid = 1'b0;
   logic [OUT_WIDTH-1:0]       model_data = '0;
   logic                       manual_valid = 1'b0;
   logic [OUT_WIDTH-1:0]       manual_data = '0;

   int   tests_run = 0;
   int   tests_failed = 0;
   int   cycle = 0;
   int   clr_run = 0;
   int   clr_pulses = 0;
   int   bad_clr = 0;
   int   fiv_count = 0;
   int   last_fiv_cycle = 0;
   int   to_count = 0;
   int   last_to_cycle = 0;
   int   out_count = 0;
   exp_t exp_q[$];

   assign fir_output_valid = model_valid | manual_valid;
   assign fir_output       = manual_valid ? manual_data : model_data;

   fir_channel_arbiter #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .IN_WIDTH(IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH), .CLR_CYCLES(CLR_CYCLES), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
      .ch_last(ch_last), .ch_ready(ch_ready), .fir_input(fir_input),
      .fir_input_valid(fir_input_valid), .fir_clr(fir_clr),
      .fir_output(fir_output), .fir_output_valid(fir_output_valid),
      .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
      .out_valid(out_valid), .timeout_err(timeout_err), .busy(busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter used to measure latencies between observed events.
   always @(posedge clk) cycle <= cycle + 1;

   // Behavioural FIR core: latches sample*20 on each input strobe and answers
   // model_delay cycles later with a one-cycle valid.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         model_valid = 1'b0;
         if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) model_valid = 1'b1;
         end
         if (fir_input_valid === 1'b1 && model_on) begin
            model_cnt  = model_delay;
            model_data = OUT_WIDTH'(fir_input) * OUT_WIDTH'(20);
         end
      end
   end

   // Event monitor and scoreboard: counts clear pulses, input strobes and
   // timeouts, and compares every out_valid against the expected queue.
   always @(negedge clk) begin
      if (fir_clr === 1'b1) begin
         clr_run++;
      end else if (clr_run > 0) begin
         clr_pulses++;
         if (clr_run != CLR_CYCLES) bad_clr++;
         clr_run = 0;
      end
      if (fir_input_valid === 1'b1) begin
         fiv_count++;
         last_fiv_cycle = cycle;
      end
      if (timeout_err === 1'b1) begin
         to_count++;
         last_to_cycle = cycle;
      end
      if (out_valid === 1'b1) begin
         exp_t e;
         out_count++;
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_unexpected: out_data=%h out_ch=%0d out_last=%0d, required no output",
                     out_data, out_ch, out_last);
         end else begin
            e = exp_q.pop_front();
            if ({out_data, out_ch, out_last} !== {e.data, e.ch, e.last}) begin
               tests_failed++;
               $display("[TB] FAIL scoreboard_result: got data=%h ch=%0d last=%0d, required data=%h ch=%0d last=%0d",
                        out_data, out_ch, out_last, e.data, e.ch, e.last);
            end
         end
      end
   end

   function automatic exp_t mk_exp(input logic [IN_WIDTH-1:0] s, input int ch, input logic last);
      exp_t e;
      e.data = OUT_WIDTH'(s) * OUT_WIDTH'(20);
      e.ch   = CH_W'(ch);
      e.last = last;
      return e;
   endfunction

   // Presents an n-sample packet on one channel, waiting (bounded) for each accept.
   task automatic send_packet(input int ch, input int n, input logic [IN_WIDTH-1:0] base);
      for (int k = 0; k < n; k++) begin
         int w = 0;
         ch_data[ch*IN_WIDTH +: IN_WIDTH] = base + IN_WIDTH'(k);
         ch_last[ch]  = (k == n - 1);
         ch_valid[ch] = 1'b1;
         #1;
         while (ch_ready[ch] !== 1'b1 && w < 3000) begin
            @(negedge clk);
            #1;
            w++;
         end
         if (ch_ready[ch] !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL send_ready_timeout: ch%0d ch_ready=%b, required 1 within 3000 cycles", ch, ch_ready[ch]);
            ch_valid[ch] = 1'b0;
            ch_last[ch]  = 1'b0;
            return;
         end
         @(negedge clk);
         ch_valid[ch] = 1'b0;
         ch_last[ch]  = 1'b0;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL wait_idle_timeout: busy=%b, required 0 within %0d cycles", busy, budget);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [65:0] obs;
      rst      = 1'b0;
      ch_valid = '1;
      repeat (3) @(negedge clk);
      obs = {ch_ready, fir_input, fir_input_valid, fir_clr, out_data, out_ch,
             out_last, out_valid, timeout_err, busy};
      tests_run++;
      if (obs !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got %h, required 0", obs);
      end
      ch_valid = '0;
      rst      = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_idle_busy: got %b, required 0", busy);
      end
   endtask

   task automatic test_single();
      int c0 = clr_pulses, b0 = bad_clr, f0 = fiv_count, o0 = out_count;
      model_on    = 1'b1;
      model_delay = 20;
      exp_q.push_back(mk_exp(16'h0005, 0, 1'b1));
      send_packet(0, 1, 16'h0005);
      tests_run++;
      if (fir_input !== 16'h0005) begin
         tests_failed++;
         $display("[TB] FAIL single_fir_input: got %h, required 0005", fir_input);
      end
      wait_idle(200);
      tests_run++;
      if (clr_pulses - c0 != 1) begin
         tests_failed++;
         $display("[TB] FAIL single_clr_count: got %0d, required 1", clr_pulses - c0);
      end
      tests_run++;
      if (bad_clr != b0) begin
         tests_failed++;
         $display("[TB] FAIL single_clr_length: got %0d bad pulses, required 0", bad_clr - b0);
      end
      tests_run++;
      if (fiv_count - f0 != 1) begin
         tests_failed++;
         $display("[TB] FAIL single_input_strobes: got %0d, required 1", fiv_count - f0);
      end
      tests_run++;
      if (out_count - o0 != 1) begin
         tests_failed++;
         $display("[TB] FAIL single_out_count: got %0d, required 1", out_count - o0);
      end
   endtask

   task automatic test_same_owner();
      int c0, viol;
      logic pkt_done;
      c0       = clr_pulses;
      viol     = 0;
      pkt_done = 1'b0;
      for (int k = 0; k < 3; k++) exp_q.push_back(mk_exp(16'h0040 + 16'(k), 1, k == 2));
      ch_data[0 +: IN_WIDTH] = 16'h0999;
      ch_last[0]  = 1'b1;
      ch_valid[0] = 1'b1;
      fork
         begin
            send_packet(1, 3, 16'h0040);
            pkt_done = 1'b1;
         end
         begin
            while (!pkt_done) begin
               @(negedge clk);
               #1;
               if (ch_ready[0] === 1'b1) viol++;
            end
         end
      join
      ch_valid[0] = 1'b0;
      ch_last[0]  = 1'b0;
      wait_idle(200);
      tests_run++;
      if (viol != 0) begin
         tests_failed++;
         $display("[TB] FAIL same_owner_foreign_ready: got %0d cycles, required 0", viol);
      end
      tests_run++;
      if (clr_pulses - c0 != 1) begin
         tests_failed++;
         $display("[TB] FAIL same_owner_first_clr: got %0d, required 1", clr_pulses - c0);
      end
      c0 = clr_pulses;
      for (int k = 0; k < 3; k++) exp_q.push_back(mk_exp(16'h0050 + 16'(k), 1, k == 2));
      send_packet(1, 3, 16'h0050);
      wait_idle(200);
      tests_run++;
      if (clr_pulses - c0 != 0) begin
         tests_failed++;
         $display("[TB] FAIL same_owner_skip_clr: got %0d, required 0", clr_pulses - c0);
      end
   endtask

   task automatic test_round_robin();
      int c0, b0, o0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      c0 = clr_pulses;
      b0 = bad_clr;
      o0 = out_count;
      exp_q.push_back(mk_exp(16'h0010, 0, 1'b1));
      exp_q.push_back(mk_exp(16'h0011, 1, 1'b1));
      exp_q.push_back(mk_exp(16'h0012, 2, 1'b1));
      exp_q.push_back(mk_exp(16'h0013, 3, 1'b1));
      exp_q.push_back(mk_exp(16'h0020, 0, 1'b1));
      fork
         begin
            send_packet(0, 1, 16'h0010);
            send_packet(0, 1, 16'h0020);
         end
         send_packet(1, 1, 16'h0011);
         send_packet(2, 1, 16'h0012);
         send_packet(3, 1, 16'h0013);
      join
      wait_idle(200);
      tests_run++;
      if (clr_pulses - c0 != 5) begin
         tests_failed++;
         $display("[TB] FAIL rr_clr_count: got %0d, required 5", clr_pulses - c0);
      end
      tests_run++;
      if (bad_clr != b0) begin
         tests_failed++;
         $display("[TB] FAIL rr_clr_length: got %0d bad pulses, required 0", bad_clr - b0);
      end
      tests_run++;
      if (out_count - o0 != 5) begin
         tests_failed++;
         $display("[TB] FAIL rr_out_count: got %0d, required 5", out_count - o0);
      end
   endtask

   task automatic test_timeout();
      int c0 = clr_pulses, t0 = to_count, o0 = out_count;
      model_on = 1'b0;
      send_packet(0, 1, 16'h0077);
      wait_idle(3000);
      tests_run++;
      if (clr_pulses - c0 != 0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_same_owner_clr: got %0d, required 0", clr_pulses - c0);
      end
      tests_run++;
      if (to_count - t0 != 1) begin
         tests_failed++;
         $display("[TB] FAIL timeout_pulse_count: got %0d, required 1", to_count - t0);
      end
      tests_run++;
      if (last_to_cycle - last_fiv_cycle != TIMEOUT + 1) begin
         tests_failed++;
         $display("[TB] FAIL timeout_latency: got %0d, required %0d", last_to_cycle - last_fiv_cycle, TIMEOUT + 1);
      end
      tests_run++;
      if (out_count - o0 != 0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_out_count: got %0d, required 0", out_count - o0);
      end
      model_on = 1'b1;
      c0 = clr_pulses;
      exp_q.push_back(mk_exp(16'h0009, 0, 1'b1));
      send_packet(0, 1, 16'h0009);
      wait_idle(200);
      tests_run++;
      if (clr_pulses - c0 != 1) begin
         tests_failed++;
         $display("[TB] FAIL timeout_forces_clr: got %0d, required 1", clr_pulses - c0);
      end
   endtask

   task automatic test_reset_in_wait();
      logic [65:0] obs;
      int c0, t0, o0;
      t0 = to_count;
      o0 = out_count;
      model_on = 1'b0;
      send_packet(2, 1, 16'h0033);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      obs = {ch_ready, fir_input, fir_input_valid, fir_clr, out_data, out_ch,
             out_last, out_valid, timeout_err, busy};
      tests_run++;
      if (obs !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_wait_outputs: got %h, required 0", obs);
      end
      rst          = 1'b1;
      manual_data  = 38'h00_0000_1234;
      manual_valid = 1'b1;
      @(negedge clk);
      manual_valid = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (out_count - o0 != 0) begin
         tests_failed++;
         $display("[TB] FAIL reset_wait_out_count: got %0d, required 0", out_count - o0);
      end
      tests_run++;
      if (to_count - t0 != 0) begin
         tests_failed++;
         $display("[TB] FAIL reset_wait_timeout: got %0d, required 0", to_count - t0);
      end
      model_on = 1'b1;
      c0 = clr_pulses;
      exp_q.push_back(mk_exp(16'h0021, 2, 1'b1));
      send_packet(2, 1, 16'h0021);
      wait_idle(200);
      tests_run++;
      if (clr_pulses - c0 != 1) begin
         tests_failed++;
         $display("[TB] FAIL reset_wait_next_clr: got %0d, required 1", clr_pulses - c0);
      end
   endtask

   task automatic test_coincident();
      exp_t e;
      int t0 = to_count, o0 = out_count;
      model_on = 1'b0;
      send_packet(3, 1, 16'h0003);
      repeat (TIMEOUT) @(negedge clk);
      e.data = 38'h20_0000_0ABC;
      e.ch   = 2'd3;
      e.last = 1'b1;
      exp_q.push_back(e);
      manual_data  = e.data;
      manual_valid = 1'b1;
      @(negedge clk);
      manual_valid = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (to_count - t0 != 0) begin
         tests_failed++;
         $display("[TB] FAIL coincident_timeout: got %0d, required 0", to_count - t0);
      end
      tests_run++;
      if (out_count - o0 != 1) begin
         tests_failed++;
         $display("[TB] FAIL coincident_out_count: got %0d, required 1", out_count - o0);
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL coincident_busy: got %b, required 0", busy);
      end
      model_on = 1'b1;
   endtask

   // Scenario sequence followed by the final scoreboard drain check.
   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_same_owner();
      test_round_robin();
      test_timeout();
      test_reset_in_wait();
      test_coincident();
      repeat (5) @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending results, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
